// File: rtl/gamemode_ctrl.sv
// gamemode_ctrl: debounced start button and collision driven game-mode FSM with timed sound windows
module gamemode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int START_CYCLES = 100000000,
  parameter int OVER_CYCLES = 150000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       collide,
  output logic [1:0] gamemode,
  output logic       mode_change,
  output logic       sound_window
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAXC = START_CYCLES > OVER_CYCLES ? START_CYCLES : OVER_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] OVER_LAST = TW'(OVER_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, PLAY = 2'b10, OVER = 2'b11} mode_t;
  mode_t state, next_state;
  logic s1, s2, db, db_q, press, expired, next_expired;
  logic [DW-1:0] db_cnt;
  logic [TW-1:0] timer, next_timer;
  assign gamemode = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      press <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn_start;
      s2 <= s1;
      db_q <= db;
      press <= db & ~db_q;
      if (s2 == db) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        db <= s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      expired <= 1'b0;
      mode_change <= 1'b0;
      sound_window <= 1'b0;
    end else begin
      state <= next_state;
      timer <= next_timer;
      expired <= next_expired;
      mode_change <= next_state != state;
      sound_window <= next_state == START || (next_state == OVER && !next_expired);
    end
  end
  // OVER keeps its timer saturated once expired so a late press is the only exit
  always_comb begin
    next_state = state;
    next_timer = timer;
    next_expired = expired;
    unique case (state)
      IDLE: if (press) begin
        next_state = START;
        next_timer = '0;
      end
      START: if (timer == START_LAST) next_state = PLAY;
        else next_timer = timer + 1'b1;
      PLAY: if (collide) begin
        next_state = OVER;
        next_timer = '0;
        next_expired = 1'b0;
      end
      OVER: if (expired && press) begin
        next_state = START;
        next_timer = '0;
      end else if (timer == OVER_LAST) next_expired = 1'b1;
        else next_timer = timer + 1'b1;
    endcase
  end
endmodule

// File: tb/tb_gamemode_ctrl.sv
// tb_gamemode_ctrl: table-driven per-cycle checks of mode, mode_change and sound_window
module tb_gamemode_ctrl;
  logic clk = 1'b0, rst = 1'b0, btn_start = 1'b0, collide = 1'b0;
  logic [1:0] gamemode;
  logic mode_change, sound_window;
  int checks = 0, errors = 0, n_step = 0;
  typedef struct {
    logic b, c, r;
    logic [1:0] m;
    logic mc, sw;
  } vec_t;
  vec_t q[$];
  gamemode_ctrl #(.DEBOUNCE_CYCLES(4), .START_CYCLES(8), .OVER_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .collide(collide),
    .gamemode(gamemode), .mode_change(mode_change), .sound_window(sound_window)
  );
  always #5 clk = ~clk;
  task automatic add(input logic b, c, r, input int n, input logic [1:0] m, input logic mc, sw);
    vec_t v;
    v.b = b; v.c = c; v.r = r; v.m = m; v.mc = mc; v.sw = sw;
    repeat (n) q.push_back(v);
  endtask
  task automatic step(input logic b, c, r, input logic [1:0] m, input logic mc, sw);
    btn_start = b;
    collide = c;
    rst = r;
    @(posedge clk);
    #1;
    n_step++;
    checks += 3;
    if (gamemode !== m) begin
      errors++;
      $display("FAIL gamemode step %0d: got %b want %b", n_step, gamemode, m);
    end
    if (mode_change !== mc) begin
      errors++;
      $display("FAIL mode_change step %0d: got %b want %b", n_step, mode_change, mc);
    end
    if (sound_window !== sw) begin
      errors++;
      $display("FAIL sound_window step %0d: got %b want %b", n_step, sound_window, sw);
    end
  endtask
  initial begin
    add(0, 0, 1, 2, 2'd0, 0, 0);
    add(0, 1, 0, 3, 2'd0, 0, 0);
    add(0, 0, 0, 2, 2'd0, 0, 0);
    repeat (5) begin
      add(1, 0, 0, 3, 2'd0, 0, 0);
      add(0, 0, 0, 1, 2'd0, 0, 0);
    end
    add(0, 0, 0, 4, 2'd0, 0, 0);
    // held press: 01 appears on the 8th edge after raw rise and lasts 8 cycles
    add(1, 0, 0, 7, 2'd0, 0, 0);
    add(1, 0, 0, 1, 2'd1, 1, 1);
    add(1, 1, 0, 2, 2'd1, 0, 1);
    add(1, 0, 0, 5, 2'd1, 0, 1);
    add(1, 0, 0, 1, 2'd2, 1, 0);
    add(0, 0, 0, 8, 2'd2, 0, 0);
    // press pulse lands in the same cycle as collide; collide wins
    add(1, 0, 0, 7, 2'd2, 0, 0);
    add(1, 1, 0, 1, 2'd3, 1, 1);
    add(1, 0, 0, 5, 2'd3, 0, 1);
    add(1, 0, 0, 3, 2'd3, 0, 0);
    add(0, 0, 0, 8, 2'd3, 0, 0);
    add(1, 0, 0, 7, 2'd3, 0, 0);
    add(1, 0, 0, 1, 2'd1, 1, 1);
    add(1, 0, 0, 7, 2'd1, 0, 1);
    add(1, 0, 0, 1, 2'd2, 1, 0);
    add(0, 0, 0, 8, 2'd2, 0, 0);
    // press pulse arrives 3 cycles into OVER and must be dropped
    add(1, 0, 0, 4, 2'd2, 0, 0);
    add(1, 1, 0, 1, 2'd3, 1, 1);
    add(1, 0, 0, 5, 2'd3, 0, 1);
    add(1, 0, 0, 4, 2'd3, 0, 0);
    add(0, 0, 0, 8, 2'd3, 0, 0);
    foreach (q[i]) step(q[i].b, q[i].c, q[i].r, q[i].m, q[i].mc, q[i].sw);
    // restart, then reset mid-START while the button stays held
    repeat (7) step(1, 0, 0, 2'd3, 0, 0);
    step(1, 0, 0, 2'd1, 1, 1);
    repeat (5) step(1, 0, 0, 2'd1, 0, 1);
    step(1, 0, 1, 2'd0, 0, 0);
    repeat (7) step(1, 0, 0, 2'd0, 0, 0);
    step(1, 0, 0, 2'd1, 1, 1);
    repeat (7) step(1, 0, 0, 2'd1, 0, 1);
    step(1, 0, 0, 2'd2, 1, 0);
    step(0, 0, 0, 2'd2, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
